// File: rtl/ccc_div_pkg.sv
// Shared defaults, channel-state layout and the high-phase helper for the
// fabric clock dividers.
package ccc_div_pkg;

  localparam int DEF_DIV_W       = 5;
  localparam int DEF_RESET_DIV   = 3;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int MAX_DIV_W       = 16;

  // Fields are sized for the widest supported divisor; narrower channels
  // only ever load zero-extended values, so the upper bits stay constant.
  typedef struct packed {
    logic [MAX_DIV_W-1:0] div;
    logic [MAX_DIV_W-1:0] cnt;
    logic [MAX_DIV_W-1:0] pdiv;
    logic                 pend;
  } ch_state_t;

  // ceil(R/2) with R = d+1, computed one bit wider so d = all-ones cannot wrap.
  function automatic logic [MAX_DIV_W:0] high_phase(input logic [MAX_DIV_W-1:0] d);
    logic [MAX_DIV_W:0] s;
    s = {1'b0, d} + (MAX_DIV_W+1)'(2);
    return s >> 1;
  endfunction

endpackage

// File: rtl/ccc_div_channel.sv
// One divider channel: wrap counter, glitch-free divisor reload, registered Y/CE.
// With FCLK_SYNC_EN defined a sync input forces a phase restart.
module ccc_div_channel
  import ccc_div_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  // we is a single-cycle strobe already qualified by the top; no back-pressure,
  // every strobe is accepted and the last one before a wrap wins.
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
`ifdef FCLK_SYNC_EN
  input  logic             sync,
`endif
  output logic             y,
  output logic             ce,
  output logic             pend
);

  ch_state_t            st;
  logic                 sync_i;
  logic                 wrap;
  logic                 apply;
  logic [MAX_DIV_W-1:0] div_n;
  logic [MAX_DIV_W-1:0] cnt_n;
  logic [MAX_DIV_W-1:0] wdiv_x;
  logic                 y_n;
  logic                 ce_n;

`ifdef FCLK_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  assign wdiv_x = MAX_DIV_W'(wdiv);
  assign pend   = st.pend;

  // A sync behaves exactly like a wrap: restart at cnt=0 and take any reload.
  always_comb begin
    wrap  = (st.cnt == st.div) | sync_i;
    apply = wrap & st.pend;
    div_n = apply ? st.pdiv : st.div;
    cnt_n = wrap ? '0 : MAX_DIV_W'(st.cnt[DIV_W-1:0] + 1'b1);
    y_n   = ({1'b0, cnt_n} < high_phase(div_n));
    ce_n  = (cnt_n == div_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st.div  <= MAX_DIV_W'(RESET_DIV);
      st.cnt  <= MAX_DIV_W'(RESET_DIV);
      st.pdiv <= '0;
      st.pend <= 1'b0;
      y       <= 1'b0;
      ce      <= 1'b0;
    end else begin
      if (en) begin
        st.div <= div_n;
        st.cnt <= cnt_n;
        if (apply) st.pend <= 1'b0;
        y  <= y_n;
        ce <= ce_n;
      end else begin
        // Parking cnt at div makes the first enabled edge a wrap.
        y  <= 1'b0;
        ce <= 1'b0;
        if (st.pend) begin
          st.div  <= st.pdiv;
          st.cnt  <= st.pdiv;
          st.pend <= 1'b0;
        end else begin
          st.cnt <= st.div;
        end
      end
      if (we) begin
        st.pdiv <= wdiv_x;
        st.pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccc_fab_clkdiv.sv
// Fabric clock conditioner: NUM_CH dividers, config decode, CFG_ERR and LOCK.
// Define FCLK_SYNC_EN to add the SYNC phase-alignment input.
module ccc_fab_clkdiv
  import ccc_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int RESET_DIV   = DEF_RESET_DIV,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLKA,
  input  logic              RST,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
`ifdef FCLK_SYNC_EN
  input  logic              SYNC,
`endif
  output logic              CFG_ERR,
  output logic [NUM_CH-1:0] Y,
  output logic [NUM_CH-1:0] CE,
  output logic [NUM_CH-1:0] PEND,
  output logic              LOCK
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam int            LC_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CYCLES);

  logic              cfg_valid;
  logic              sync_i;
  logic [NUM_CH-1:0] ch_we;
  logic [LC_W-1:0]   lc;

`ifdef FCLK_SYNC_EN
  assign sync_i = SYNC;
`else
  assign sync_i = 1'b0;
`endif

  assign cfg_valid = CFG_WE & ({1'b0, CFG_CH} < NUM_CH_L);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = cfg_valid & (CFG_CH == CH_W'(i));

    ccc_div_channel #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk  (CLKA),
      .rst  (RST),
      .en   (CH_EN[i]),
      .we   (ch_we[i]),
      .wdiv (CFG_DIV),
`ifdef FCLK_SYNC_EN
      .sync (SYNC),
`endif
      .y    (Y[i]),
      .ce   (CE[i]),
      .pend (PEND[i])
    );
  end

  // LOCK follows the counter one edge late, so it drops one cycle after the
  // disturbing write and rises LOCK_CYCLES+1 edges after the last one.
  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      lc      <= '0;
      LOCK    <= 1'b0;
      CFG_ERR <= 1'b0;
    end else begin
      CFG_ERR <= CFG_WE & ~cfg_valid;
      LOCK    <= (lc == LC_MAX);
      if (cfg_valid | (|PEND) | sync_i) begin
        lc <= '0;
      end else if (lc != LC_MAX) begin
        lc <= lc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccc_fab_clkdiv.sv
// Bench for ccc_fab_clkdiv: ratio/phase model plus directed literal checks.
// NUM_CH=5 so that channel indices 5..7 are representable but invalid.
module tb_ccc_fab_clkdiv;

  localparam int NUM_CH      = 5;
  localparam int DIV_W       = 5;
  localparam int RESET_DIV   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W        = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              sync;
  logic              cfg_err;
  logic [NUM_CH-1:0] y;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] pend;
  logic              lock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  ccc_fab_clkdiv #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .RESET_DIV   (RESET_DIV),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .CLKA    (clk),
    .RST     (rst),
    .CH_EN   (ch_en),
    .CFG_WE  (cfg_we),
    .CFG_CH  (cfg_ch),
    .CFG_DIV (cfg_div),
`ifdef FCLK_SYNC_EN
    .SYNC    (sync),
`endif
    .CFG_ERR (cfg_err),
    .Y       (y),
    .CE      (ce),
    .PEND    (pend),
    .LOCK    (lock)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 60) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is a ratio R and a position inside the current period.
  int                m_r   [NUM_CH];
  int                m_pos [NUM_CH];
  int                m_pr  [NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_restart, m_y, m_ce;
  int                m_lc;
  logic              m_lock, m_err;

  always @(posedge clk) begin : p_model
    bit valid, any_pend, syn, lock_new;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_r[c] = RESET_DIV + 1; m_pos[c] = 0; m_pr[c] = 1;
      end
      m_pend = '0; m_restart = '1; m_y = '0; m_ce = '0;
      m_lc = 0; m_lock = 1'b0; m_err = 1'b0;
    end else begin
      valid = cfg_we && (int'(cfg_ch) < NUM_CH);
`ifdef FCLK_SYNC_EN
      syn = sync;
`else
      syn = 1'b0;
`endif
      any_pend = |m_pend;
      m_err    = cfg_we && !valid;
      lock_new = (m_lc == LOCK_CYCLES);
      if (valid || any_pend || syn) m_lc = 0;
      else if (m_lc < LOCK_CYCLES) m_lc++;
      m_lock = lock_new;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_en[c]) begin
          if (m_restart[c] || m_pos[c] == m_r[c] - 1 || syn) begin
            if (m_pend[c]) begin m_r[c] = m_pr[c]; m_pend[c] = 1'b0; end
            m_pos[c] = 0;
            m_restart[c] = 1'b0;
          end else begin
            m_pos[c]++;
          end
          m_y[c]  = (m_pos[c] < (m_r[c] + 1) / 2);
          m_ce[c] = (m_pos[c] == m_r[c] - 1);
        end else begin
          if (m_pend[c]) begin m_r[c] = m_pr[c]; m_pend[c] = 1'b0; end
          m_restart[c] = 1'b1;
          m_y[c] = 1'b0;
          m_ce[c] = 1'b0;
        end
        if (valid && int'(cfg_ch) == c) begin
          m_pr[c] = int'(cfg_div) + 1;
          m_pend[c] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_y",    32'(y),       32'(m_y));
      check("model_ce",   32'(ce),      32'(m_ce));
      check("model_pend", 32'(pend),    32'(m_pend));
      check("model_lock", 32'(lock),    32'(m_lock));
      check("model_err",  32'(cfg_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic capture(input int ch, input int n, output logic [31:0] yb, output logic [31:0] cb);
    yb = '0; cb = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      yb[i] = y[ch];
      cb[i] = ce[ch];
    end
  endtask

  task automatic write(input int ch, input int dv);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv);
  endtask

  task automatic wait_lock(input int start, input int bound, output int e);
    e = start;
    while (!lock && e < bound) begin step(); e++; end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] yb, cb;
    int e;
    int bad[2] = '{5, 7};
    rst = 1'b1; ch_en = '1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    check("rst_y", 32'(y), 0);
    check("rst_ce", 32'(ce), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;

    // Default divide-by-4 from the first edge, LOCK on edge 17.
    capture(0, 8, yb, cb);
    check("def_y0", yb, 32'b00110011);
    check("def_ce0", cb, 32'b10001000);
    wait_lock(8, 40, e);
    check("lock_edge", e, 17);

    // Reload ch1 to div=4 while its cnt=1.
    step();
    write(1, 4);
    step();
    cfg_we = 1'b0;
    check("wr_pend1", 32'(pend[1]), 1);
    check("wr_lock_hold", 32'(lock), 1);
    step();
    check("wr_lock_drop", 32'(lock), 0);
    check("wr_old_y1", 32'(y[1]), 0);
    check("wr_old_ce1", 32'(ce[1]), 1);
    capture(1, 10, yb, cb);
    check("div4_y1", yb, 32'b0011100111);
    check("div4_ce1", cb, 32'b1000010000);
    check("div4_pend1", 32'(pend[1]), 0);

    // Two writes to ch2 before its wrap: only the last applies.
    write(2, 7);
    step();
    write(2, 1);
    step();
    cfg_we = 1'b0;
    check("dbl_pend2", 32'(pend[2]), 1);
    capture(2, 8, yb, cb);
    check("div1_y2", yb, 32'b01010101);
    check("div1_ce2", cb, 32'b10101010);

    // Out-of-range channel writes.
    wait_lock(0, 40, e);
    check("relock", 32'(lock), 1);
    foreach (bad[k]) begin
      write(bad[k], 9);
      step();
      cfg_we = 1'b0;
      check("bad_err", 32'(cfg_err), 1);
      check("bad_pend", 32'(pend), 0);
      check("bad_lock", 32'(lock), 1);
      step();
      check("bad_err_clr", 32'(cfg_err), 0);
    end

    // Disabled channel takes its pending reload immediately.
    ch_en[0] = 1'b0;
    write(0, 0);
    step();
    cfg_we = 1'b0;
    check("dis_y0", 32'(y[0]), 0);
    check("dis_pend0", 32'(pend[0]), 1);
    step();
    check("dis_pend0_clr", 32'(pend[0]), 0);
    repeat (3) step();
    check("dis_y0_hold", 32'(y[0]), 0);
    ch_en[0] = 1'b1;
    capture(0, 6, yb, cb);
    check("div0_y0", yb, 32'b111111);
    check("div0_ce0", cb, 32'b111111);

    // Reset mid-operation discards a pending write.
    write(3, 9);
    step();
    cfg_we = 1'b0;
    check("mid_pend3", 32'(pend[3]), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_pend", 32'(pend), 0);
    check("mid_rst_lock", 32'(lock), 0);
    step(); step();
    rst = 1'b0;
    capture(3, 4, yb, cb);
    check("mid_y3", yb, 32'b0011);
    check("mid_ce3", cb, 32'b1000);

`ifdef FCLK_SYNC_EN
    write(1, 4); step();
    write(2, 5); step();
    cfg_we = 1'b0;
    wait_lock(0, 60, e);
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_y", 32'(y), 32'b11111);
    check("sync_ce", 32'(ce), 0);
    capture(2, 6, yb, cb);
    check("sync_y2", yb, 32'b100011);
    check("sync_ce2", cb, 32'b010000);
    wait_lock(6, 60, e);
    check("sync_lock_edge", e, 17);
`endif

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_ch  = CH_W'($urandom_range(0, 7));
      cfg_div = DIV_W'($urandom_range(0, 31));
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 29) == 0) ch_en[c] = ~ch_en[c];
`ifdef FCLK_SYNC_EN
      sync = ($urandom_range(0, 39) == 0);
`endif
      step();
    end
    cfg_we = 1'b0; sync = 1'b0; ch_en = '1;
    repeat (80) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
